// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions for the fetch-side predictor and EX resolve.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bp_pkg;

    // RV32 control-transfer opcodes
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Conditional-branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Predictor geometry: index = pc[8:2], tag = pc[11:9]
    localparam int IDX_W = 7;
    localparam int TAG_W = 3;

    // BHT entry as stored by the predictor
    typedef struct packed {
        logic [1:0]       state;
        logic [TAG_W-1:0] tag;
    } bht_entry_t;

    // BTB entry as stored by the predictor (word-aligned target within a 4 KiB page)
    typedef struct packed {
        logic             valid;
        logic [9:0]       target;
        logic [TAG_W-1:0] tag;
    } btb_entry_t;

    // 2-bit saturating direction counter: 00 strong-NT .. 11 strong-T
    function automatic logic [1:0] sat2_next(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        nxt = state;
        if (taken) begin
            if (state != 2'b11) nxt = state + 2'd1;
        end else begin
            if (state != 2'b00) nxt = state - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates the conditional-branch compare selected by funct3.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module branch_cond_eval
    import bp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_val == rs2_val);
    assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
    assign lt_u = (rs1_val < rs2_val);

    // Select the condition; reserved encodings 010/011 resolve not-taken
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = ~lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = ~lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/JALR in EX: redirect + flush, predictor write-back, perf counters.
// Latency: direction/redirect/flush combinational in EX; BHT/BTB updates 1 cycle later.
// Backpressure: stall_e holds the instruction with no side effects; re-evaluated on release.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int IDX_W        = 7,
    parameter int TAG_W        = 3,
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_e,
    input  logic                  stall_e,
    input  logic [6:0]            opcode_e,
    input  logic [2:0]            funct3_e,
    input  logic [XLEN-1:0]       rs1_val_e,
    input  logic [XLEN-1:0]       rs2_val_e,
    input  logic [XLEN-1:0]       pc_e,
    input  logic [XLEN-1:0]       imm_e,
    input  logic [1:0]            state_e,
    input  logic                  prediction_made_e,
    input  logic                  jalr_addr_req_e,
    input  logic                  cnt_clear,
    output logic                  br_actual,
    output logic                  prediction_correct,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  upd_bht_en,
    output logic [IDX_W-1:0]      upd_bht_idx,
    output logic [2+TAG_W-1:0]    upd_bht_entry,
    output logic                  upd_btb_en,
    output logic [IDX_W-1:0]      upd_btb_idx,
    output logic [1+10+TAG_W-1:0] upd_btb_entry,
    output logic [CNT_W-1:0]      cnt_branches,
    output logic [CNT_W-1:0]      cnt_mispredicts,
    output logic [CNT_W-1:0]      cnt_jalr_misses
);

    import bp_pkg::*;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } flush_state_t;

    // The redirect cycle itself is flushed combinationally, so FLUSH covers FLUSH_CYCLES-1 cycles
    localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = (FLUSH_CYCLES > 1) ? FCNT_W'(FLUSH_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    flush_state_t      fstate;
    logic [FCNT_W-1:0] fcnt;

    logic            squash;
    logic            acc;
    logic            is_branch;
    logic            cond_taken;
    logic            mispredict;
    logic            jalr_req;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;
    logic [1:0]      new_state;
    bht_entry_t      bht_q;
    btb_entry_t      btb_q;

    branch_cond_eval #(
        .XLEN (XLEN)
    ) u_cond (
        .funct3  (funct3_e),
        .rs1_val (rs1_val_e),
        .rs2_val (rs2_val_e),
        .taken   (cond_taken)
    );

    // Instructions arriving while the pipe is being squashed are wrong-path and ignored
    assign squash    = (fstate == S_FLUSH);
    assign acc       = valid_e & ~stall_e & ~squash;
    assign is_branch = (opcode_e == OPC_BRANCH);

    assign br_actual          = acc & is_branch & cond_taken;
    assign mispredict         = acc & prediction_made_e & (br_actual != state_e[1]);
    assign prediction_correct = ~mispredict;
    assign jalr_req           = acc & jalr_addr_req_e;

    assign br_target   = pc_e + imm_e;
    assign seq_pc      = pc_e + XLEN'(4);
    assign jalr_sum    = rs1_val_e + imm_e;
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

    assign new_state = sat2_next(state_e, br_actual);

    // Redirect selection: direction mispredict outranks a JALR target miss
    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (mispredict) begin
            redirect_valid = 1'b1;
            redirect_pc    = br_actual ? br_target : seq_pc;
        end else if (jalr_req) begin
            redirect_valid = 1'b1;
            redirect_pc    = jalr_target;
        end
    end

    assign flush_if_id = redirect_valid | squash;
    assign flush_id_ex = redirect_valid | squash;

    // Flush sequencer: hold the squash for the remaining cycles after a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            fstate <= S_IDLE;
            fcnt   <= '0;
        end else begin
            case (fstate)
                S_IDLE: begin
                    if (redirect_valid && (FLUSH_CYCLES > 1)) begin
                        fstate <= S_FLUSH;
                        fcnt   <= FCNT_LOAD;
                    end
                end
                S_FLUSH: begin
                    if (fcnt == '0) begin
                        fstate <= S_IDLE;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                default: begin
                    fstate <= S_IDLE;
                    fcnt   <= '0;
                end
            endcase
        end
    end

    // Predictor write-back: strobes pulse for one cycle, payload holds until next write
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_bht_en  <= 1'b0;
            upd_bht_idx <= '0;
            bht_q       <= '0;
            upd_btb_en  <= 1'b0;
            upd_btb_idx <= '0;
            btb_q       <= '0;
        end else begin
            upd_bht_en <= acc & prediction_made_e;
            upd_btb_en <= jalr_req;
            if (acc && prediction_made_e) begin
                upd_bht_idx <= pc_e[2 +: IDX_W];
                bht_q.state <= new_state;
                bht_q.tag   <= pc_e[2+IDX_W +: TAG_W];
            end
            if (jalr_req) begin
                upd_btb_idx  <= pc_e[2 +: IDX_W];
                btb_q.valid  <= 1'b1;
                btb_q.target <= jalr_target[11:2];
                btb_q.tag    <= pc_e[2+IDX_W +: TAG_W];
            end
        end
    end

    assign upd_bht_entry = bht_q;
    assign upd_btb_entry = btb_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && (cnt != CNT_MAX)) nxt = cnt + 1'b1;
        return nxt;
    endfunction

    // Saturating event counters; a clear takes precedence over a same-cycle event
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
            cnt_jalr_misses <= '0;
        end else begin
            cnt_branches    <= sat_inc(cnt_branches, acc & is_branch);
            cnt_mispredicts <= sat_inc(cnt_mispredicts, mispredict);
            cnt_jalr_misses <= sat_inc(cnt_jalr_misses, jalr_req);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboarded bench for branch_resolve_unit with directed vectors.
// Stimulus pushes expected redirects/updates; a negedge monitor pops and compares them.
// Immediate direction/flush/counter values are compared inline by the stimulus.
module tb_branch_resolve_unit;
    import bp_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_e;
    logic        stall_e;
    logic [6:0]  opcode_e;
    logic [2:0]  funct3_e;
    logic [31:0] rs1_val_e;
    logic [31:0] rs2_val_e;
    logic [31:0] pc_e;
    logic [31:0] imm_e;
    logic [1:0]  state_e;
    logic        prediction_made_e;
    logic        jalr_addr_req_e;
    logic        cnt_clear;
    logic        br_actual;
    logic        prediction_correct;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        upd_bht_en;
    logic [6:0]  upd_bht_idx;
    logic [4:0]  upd_bht_entry;
    logic        upd_btb_en;
    logic [6:0]  upd_btb_idx;
    logic [13:0] upd_btb_entry;
    logic [3:0]  cnt_branches;
    logic [3:0]  cnt_mispredicts;
    logic [3:0]  cnt_jalr_misses;

    branch_resolve_unit #(
        .XLEN         (32),
        .IDX_W        (7),
        .TAG_W        (3),
        .CNT_W        (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .valid_e            (valid_e),
        .stall_e            (stall_e),
        .opcode_e           (opcode_e),
        .funct3_e           (funct3_e),
        .rs1_val_e          (rs1_val_e),
        .rs2_val_e          (rs2_val_e),
        .pc_e               (pc_e),
        .imm_e              (imm_e),
        .state_e            (state_e),
        .prediction_made_e  (prediction_made_e),
        .jalr_addr_req_e    (jalr_addr_req_e),
        .cnt_clear          (cnt_clear),
        .br_actual          (br_actual),
        .prediction_correct (prediction_correct),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .flush_if_id        (flush_if_id),
        .flush_id_ex        (flush_id_ex),
        .upd_bht_en         (upd_bht_en),
        .upd_bht_idx        (upd_bht_idx),
        .upd_bht_entry      (upd_bht_entry),
        .upd_btb_en         (upd_btb_en),
        .upd_btb_idx        (upd_btb_idx),
        .upd_btb_entry      (upd_btb_entry),
        .cnt_branches       (cnt_branches),
        .cnt_mispredicts    (cnt_mispredicts),
        .cnt_jalr_misses    (cnt_jalr_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] idx;
        logic [4:0] entry;
    } bht_exp_t;

    typedef struct packed {
        logic [6:0]  idx;
        logic [13:0] entry;
    } btb_exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q_redir[$];
    bht_exp_t    q_bht[$];
    btb_exp_t    q_btb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [1:0] s, input logic pm, input logic jr);
        valid_e           = v;
        stall_e           = st;
        opcode_e          = op;
        funct3_e          = f3;
        rs1_val_e         = a;
        rs2_val_e         = b;
        pc_e              = pc;
        imm_e             = imm;
        state_e           = s;
        prediction_made_e = pm;
        jalr_addr_req_e   = jr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every redirect / BHT / BTB strobe must match the head of its queue
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (redirect_valid) begin
                    if (q_redir.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_redirect: got pc 0x%0h, required no redirect", redirect_pc);
                    end else begin
                        check("redirect_pc", 64'(redirect_pc), 64'(q_redir.pop_front()));
                    end
                end
                if (upd_bht_en) begin
                    if (q_bht.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_bht_upd: got idx 0x%0h entry 0x%0h, required none", upd_bht_idx, upd_bht_entry);
                    end else begin
                        check("bht_upd", 64'({upd_bht_idx, upd_bht_entry}), 64'(q_bht.pop_front()));
                    end
                end
                if (upd_btb_en) begin
                    if (q_btb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_btb_upd: got idx 0x%0h entry 0x%0h, required none", upd_btb_idx, upd_btb_entry);
                    end else begin
                        check("btb_upd", 64'({upd_btb_idx, upd_btb_entry}), 64'(q_btb.pop_front()));
                    end
                end
                check("flush_pair", 64'(flush_if_id), 64'(flush_id_ex));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        cnt_clear = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_redirect", 64'(redirect_valid), 64'd0);
        check("rst_flush", 64'(flush_if_id), 64'd0);
        check("rst_bht_en", 64'(upd_bht_en), 64'd0);
        check("rst_btb_en", 64'(upd_btb_en), 64'd0);
        check("rst_cnt_br", 64'(cnt_branches), 64'd0);
        check("rst_cnt_mp", 64'(cnt_mispredicts), 64'd0);
        check("rst_cnt_jm", 64'(cnt_jalr_misses), 64'd0);
        check("rst_pc_ok", 64'(prediction_correct), 64'd1);

        // BEQ taken, predicted weakly not-taken -> redirect to pc+imm
        next_cycle();
        drive(1'b1, 1'b0, OPC_BRANCH, F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h40, 2'b01, 1'b1, 1'b0);
        q_redir.push_back(32'h140);
        q_bht.push_back('{idx: 7'h40, entry: 5'b10_000});
        @(negedge clk);
        check("beq_br_actual", 64'(br_actual), 64'd1);
        check("beq_pc_ok", 64'(prediction_correct), 64'd0);
        check("beq_redirect", 64'(redirect_valid), 64'd1);
        check("beq_flush_c0", 64'(flush_if_id), 64'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("beq_flush_c1", 64'(flush_id_ex), 64'd1);
        check("beq_cnt_br", 64'(cnt_branches), 64'd1);
        check("beq_cnt_mp", 64'(cnt_mispredicts), 64'd1);
        next_cycle();
        @(negedge clk);
        check("beq_flush_c2", 64'(flush_if_id), 64'd0);

        // BLTU: 0xFFFFFFFF < 1 unsigned is false
        next_cycle();
        drive(1'b1, 1'b0, OPC_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 2'b00, 1'b1, 1'b0);
        q_bht.push_back('{idx: 7'h00, entry: 5'b00_001});
        @(negedge clk);
        check("bltu_br_actual", 64'(br_actual), 64'd0);
        check("bltu_pc_ok", 64'(prediction_correct), 64'd1);
        check("bltu_redirect", 64'(redirect_valid), 64'd0);

        // BLT: -1 < 1 signed is true, strongly taken predicted
        next_cycle();
        drive(1'b1, 1'b0, OPC_BRANCH, F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h104, 32'h10, 2'b11, 1'b1, 1'b0);
        q_bht.push_back('{idx: 7'h41, entry: 5'b11_000});
        @(negedge clk);
        check("blt_br_actual", 64'(br_actual), 64'd1);
        check("blt_pc_ok", 64'(prediction_correct), 64'd1);
        check("blt_cnt_br", 64'(cnt_branches), 64'd2);

        // BGE: -1 >= 1 false, predicted weakly taken -> redirect to pc+4
        next_cycle();
        drive(1'b1, 1'b0, OPC_BRANCH, F3_BGE, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h80, 2'b10, 1'b1, 1'b0);
        q_redir.push_back(32'h304);
        q_bht.push_back('{idx: 7'h40, entry: 5'b01_001});
        @(negedge clk);
        check("bge_br_actual", 64'(br_actual), 64'd0);
        check("bge_pc_ok", 64'(prediction_correct), 64'd0);
        check("bge_flush", 64'(flush_if_id), 64'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("bge_cnt_br", 64'(cnt_branches), 64'd4);
        check("bge_cnt_mp", 64'(cnt_mispredicts), 64'd2);
        next_cycle();

        // Reserved funct3 010 resolves not-taken but still counts as a branch
        next_cycle();
        drive(1'b1, 1'b0, OPC_BRANCH, 3'b010, 32'd7, 32'd7, 32'h600, 32'h10, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check("f3_010_br_actual", 64'(br_actual), 64'd0);
        check("f3_010_redirect", 64'(redirect_valid), 64'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("f3_010_cnt_br", 64'(cnt_branches), 64'd5);

        // JALR BTB miss: target (0x2001+4)&~1 = 0x2004
        next_cycle();
        drive(1'b1, 1'b0, OPC_JALR, 3'b000, 32'h2001, 32'd0, 32'hA04, 32'd4, 2'b00, 1'b0, 1'b1);
        q_redir.push_back(32'h2004);
        q_btb.push_back('{idx: 7'h01, entry: {1'b1, 10'h001, 3'b101}});
        @(negedge clk);
        check("jalr_br_actual", 64'(br_actual), 64'd0);
        check("jalr_flush", 64'(flush_id_ex), 64'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("jalr_cnt_jm", 64'(cnt_jalr_misses), 64'd1);
        check("jalr_cnt_br", 64'(cnt_branches), 64'd5);
        next_cycle();

        // Mispredict then a second mispredicting branch inside FLUSH: second ignored
        next_cycle();
        drive(1'b1, 1'b0, OPC_BRANCH, F3_BNE, 32'd1, 32'd2, 32'h400, 32'h20, 2'b00, 1'b1, 1'b0);
        q_redir.push_back(32'h420);
        q_bht.push_back('{idx: 7'h00, entry: 5'b01_010});
        @(negedge clk);
        check("bne1_redirect", 64'(redirect_valid), 64'd1);
        next_cycle();
        @(negedge clk);
        check("bne2_redirect", 64'(redirect_valid), 64'd0);
        check("bne2_flush", 64'(flush_if_id), 64'd1);
        check("bne2_br_actual", 64'(br_actual), 64'd0);
        check("bne2_pc_ok", 64'(prediction_correct), 64'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("bne_flush_end", 64'(flush_if_id), 64'd0);
        check("bne_cnt_br", 64'(cnt_branches), 64'd6);
        check("bne_cnt_mp", 64'(cnt_mispredicts), 64'd3);

        // Stalled mispredicting BEQ for 3 cycles, then released
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b1, 1'b1, OPC_BRANCH, F3_BEQ, 32'd3, 32'd4, 32'h500, 32'h40, 2'b11, 1'b1, 1'b0);
            @(negedge clk);
            check("stall_redirect", 64'(redirect_valid), 64'd0);
            check("stall_pc_ok", 64'(prediction_correct), 64'd1);
            check("stall_cnt_br", 64'(cnt_branches), 64'd6);
        end
        next_cycle();
        stall_e = 1'b0;
        q_redir.push_back(32'h504);
        q_bht.push_back('{idx: 7'h40, entry: 5'b10_010});
        @(negedge clk);
        check("release_redirect", 64'(redirect_valid), 64'd1);
        check("release_pc_ok", 64'(prediction_correct), 64'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("release_cnt_br", 64'(cnt_branches), 64'd7);
        check("release_cnt_mp", 64'(cnt_mispredicts), 64'd4);
        next_cycle();

        // Clear, then drive 17 correctly-unpredicted branches into the 4-bit counter
        next_cycle();
        cnt_clear = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            next_cycle();
            cnt_clear = 1'b0;
            drive(1'b1, 1'b0, OPC_BRANCH, F3_BEQ, 32'd5, 32'd5, 32'h700, 32'h10, 2'b00, 1'b0, 1'b0);
            @(negedge clk);
            check("sat_ramp", 64'(cnt_branches), (i > 15) ? 64'd15 : 64'(i));
        end
        next_cycle();
        idle();
        @(negedge clk);
        check("sat_hold", 64'(cnt_branches), 64'hF);
        check("sat_cnt_mp", 64'(cnt_mispredicts), 64'd0);
        check("sat_cnt_jm", 64'(cnt_jalr_misses), 64'd0);

        // Clear with a simultaneous branch: clear wins
        next_cycle();
        drive(1'b1, 1'b0, OPC_BRANCH, F3_BEQ, 32'd5, 32'd5, 32'h700, 32'h10, 2'b00, 1'b0, 1'b0);
        cnt_clear = 1'b1;
        @(negedge clk);
        next_cycle();
        idle();
        cnt_clear = 1'b0;
        @(negedge clk);
        check("clear_wins", 64'(cnt_branches), 64'd0);

        next_cycle();
        @(negedge clk);
        check("redir_queue_empty", 64'(q_redir.size()), 64'd0);
        check("bht_queue_empty", 64'(q_bht.size()), 64'd0);
        check("btb_queue_empty", 64'(q_btb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage counterpart of the fetch-side branch predictor. It resolves conditional branches and JALR in EX and produces br_actual, prediction_correct and the redirect/flush controls. It generates the registered BHT/BTB write-back entries in the predictor's {state, tag} and {valid, target[11:2], tag} formats. It also keeps saturating performance counters for branch, mispredict and JALR-miss events.

Parameters:
XLEN, 32, datapath width
IDX_W, 7, predictor index width (pc[8:2])
TAG_W, 3, predictor tag width (pc[11:9])
CNT_W, 32, performance counter width
FLUSH_CYCLES, 2, cycles flush_if_id/flush_id_ex stay high per redirect (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
valid_e  in  1  EX holds a real instruction
stall_e  in  1  EX held; no event accepted
opcode_e  in  7  EX opcode
funct3_e  in  3  branch condition
rs1_val_e  in  XLEN  forwarded rs1
rs2_val_e  in  XLEN  forwarded rs2
pc_e  in  XLEN  EX pc
imm_e  in  XLEN  sign-extended immediate
state_e  in  2  predictor state carried with the instruction
prediction_made_e  in  1  fetch made a direction prediction
jalr_addr_req_e  in  1  fetch had a JALR BTB miss
cnt_clear  in  1  sync clear of all counters
br_actual  out  1  resolved direction
prediction_correct  out  1  prediction matched outcome
redirect_valid  out  1  fetch must redirect this cycle
redirect_pc  out  XLEN  redirect target
flush_if_id  out  1  squash IF/ID
flush_id_ex  out  1  squash ID/EX
upd_bht_en  out  1  BHT write strobe
upd_bht_idx  out  IDX_W  BHT index
upd_bht_entry  out  2+TAG_W  {new_state, tag}
upd_btb_en  out  1  BTB write strobe
upd_btb_idx  out  IDX_W  BTB index
upd_btb_entry  out  1+10+TAG_W  {1, target[11:2], tag}
cnt_branches  out  CNT_W  resolved conditional branches
cnt_mispredicts  out  CNT_W  wrong direction predictions
cnt_jalr_misses  out  CNT_W  JALR BTB misses

Behaviour:
- Accept condition: acc = valid_e & ~stall_e & ~squash. squash = FSM in FLUSH.
- Branch (opcode 1100011) conditions, by funct3:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE (signed).
  - 110 BLTU, 111 BGEU (unsigned).
  - 010/011 resolve not-taken.
- br_actual is combinational. It is 0 for non-branches and when acc=0.
- Predicted taken = state_e[1].
- prediction_correct = ~(acc & prediction_made_e & (br_actual != state_e[1])). It is 1 when not applicable.
- JALR target = (rs1_val_e + imm_e) & ~1, with XLEN wrap.
- Redirect (combinational, same cycle as EX), priority order:
  1. Mispredict: redirect_pc = br_actual ? pc_e+imm_e : pc_e+4.
  2. acc & jalr_addr_req_e: redirect_pc = JALR target.
  3. Otherwise redirect_valid=0 and redirect_pc=0.
- new_state: 2-bit saturating counter. 00/01/10/11, up on taken, down on not-taken.
- Updates are registered with 1-cycle latency. upd_*_en is a one-cycle pulse, zero otherwise.
  - BHT, on acc & prediction_made_e: idx = pc_e[8:2], entry = {new_state, pc_e[11:9]}.
  - BTB, on acc & jalr_addr_req_e: idx = pc_e[8:2], entry = {1, target[11:2], pc_e[11:9]}.
- Flush FSM, states IDLE and FLUSH, with down-counter fcnt:
  - flush_if_id = flush_id_ex = redirect_valid | (state==FLUSH).
  - IDLE -> FLUSH on redirect_valid when FLUSH_CYCLES>1, loading fcnt = FLUSH_CYCLES-2.
  - In FLUSH, fcnt decrements each cycle, independent of stall_e. At fcnt==0, return to IDLE.
  - A redirect cannot occur in FLUSH because acc is masked.
- Counters, updated on acc, saturating at all-ones:
  - cnt_branches +1 per conditional branch.
  - cnt_mispredicts +1 per mispredict.
  - cnt_jalr_misses +1 per jalr_addr_req_e.
  - cnt_clear wins over a same-cycle increment.
- Reset: FSM IDLE, fcnt 0, all registered outputs and counters 0.
- Reset mid-flush aborts the flush: flush outputs drop the next cycle unless a new redirect occurs.
- stall_e during a branch: no update, no count, no redirect. The branch is evaluated again when the stall releases.

Decomposition:
- Shared package bp_pkg:
  - OPC_BRANCH, OPC_JALR, OPC_JAL.
  - funct3 constants.
  - bht_entry_t and btb_entry_t packed structs.
  - IDX_W and TAG_W.
  - Function sat2_next(state, taken), which the fetch-side predictor should also use.
- Sub-module: branch_cond_eval (combinational compare on funct3/rs1/rs2). Everything else stays in the top.

Test Plan:
- BEQ rs1=rs2=5, state_e=01, prediction_made_e=1, pc_e=0x100, imm=0x40:
  - Same cycle: br_actual=1, prediction_correct=0, redirect_pc=0x140, both flushes high.
  - Next cycle: upd_bht_en=1, idx=0x40, entry={10,000}; flushes high 2 cycles total.
- BLTU rs1=0xFFFFFFFF, rs2=1, state_e=00 -> not taken, prediction_correct=1, no redirect. Next cycle BHT entry state 00.
- JALR with jalr_addr_req_e=1, rs1=0x2001, imm=4, pc_e=0xA04:
  - redirect_pc=0x2004.
  - Next cycle: upd_btb_idx=0x01, entry={1, 0x001, 101}.
  - cnt_jalr_misses=1.
- Mispredict followed by a valid mispredicting branch in the next cycle (inside FLUSH) -> the second is ignored: no redirect, counters unchanged, FSM returns to IDLE after 2 cycles.
- stall_e=1 on a mispredicting branch for 3 cycles, then 0 -> a single redirect/update/count, occurring only in the release cycle.
- Preload cnt_branches to all-ones via 2^CNT_W events (bench with CNT_W=4) -> stays 0xF. cnt_clear with a simultaneous branch -> 0.
